// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg -- shared definitions for the integer ALU reservation station.
//   * internal opcode constants (ADD .. JALR)
//   * default ROB tag width and RS depth
//   * payload struct for the fields an entry carries unchanged to the ALU
package alu_rs_pkg;

    localparam int RS_SIZE_DEF = 8;
    localparam int ROBENTRY_W  = 4;
    localparam int OPC_W       = 6;

    localparam logic [OPC_W-1:0] OP_ADD   = 6'd0;
    localparam logic [OPC_W-1:0] OP_SUB   = 6'd1;
    localparam logic [OPC_W-1:0] OP_AND   = 6'd2;
    localparam logic [OPC_W-1:0] OP_OR    = 6'd3;
    localparam logic [OPC_W-1:0] OP_XOR   = 6'd4;
    localparam logic [OPC_W-1:0] OP_SLL   = 6'd5;
    localparam logic [OPC_W-1:0] OP_SRL   = 6'd6;
    localparam logic [OPC_W-1:0] OP_SRA   = 6'd7;
    localparam logic [OPC_W-1:0] OP_SLT   = 6'd8;
    localparam logic [OPC_W-1:0] OP_SLTU  = 6'd9;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'd10;
    localparam logic [OPC_W-1:0] OP_LUI   = 6'd11;
    localparam logic [OPC_W-1:0] OP_AUIPC = 6'd12;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'd13;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'd14;
    localparam logic [OPC_W-1:0] OP_BLT   = 6'd15;
    localparam logic [OPC_W-1:0] OP_BGE   = 6'd16;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'd17;
    localparam logic [OPC_W-1:0] OP_JALR  = 6'd18;

    // Fields that never change after issue.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [31:0]      imm;
        logic [31:0]      pc;
    } rs_payload_t;

endpackage

// File: rtl/alu_rs_select.sv
// alu_rs_select -- combinational dispatch arbiter.
//   ready : per-entry ready vector
//   older : (ALU_RS_OLDEST_FIRST_EN only) older[i][j]=1 -> i issued before j
//   grant : one-hot winner, found : any entry ready
// Macro ALU_RS_OLDEST_FIRST_EN selects oldest-ready; otherwise lowest index.
module alu_rs_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]          ready,
`ifdef ALU_RS_OLDEST_FIRST_EN
    input  logic [N-1:0][N-1:0]   older,
`endif
    output logic [N-1:0]          grant,
    output logic                  found
);

`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [N-1:0] blocked;

    // An entry loses if any other ready entry is older than it.
    always_comb begin
        blocked = '0;
        grant   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j != i && ready[j] && older[j][i])
                    blocked[i] = 1'b1;
            end
            grant[i] = ready[i] && !blocked[i];
        end
        found = |ready;
    end
`else
    logic taken;

    always_comb begin
        grant = '0;
        taken = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && !taken) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
            end
        end
        found = |ready;
    end
`endif

endmodule

// File: rtl/alu_rs.sv
// alu_rs -- reservation station feeding the integer ALU (Tomasulo core).
//   clk/rst (async, active-low), rdy (freeze), clear (sync flush)
//   issue_* : renamed op from issue stage; full : no free entry
//   alu_cdb_* / lsb_cdb_* : result broadcasts used for wakeup and bypass
//   alu_*   : registered dispatch to the ALU, alu_sgn pulses once per op
// Macro ALU_RS_OLDEST_FIRST_EN: age matrix, oldest ready op dispatches first.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int ROB_W   = ROBENTRY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              issue_sgn,
    input  logic [5:0]        issue_opcode,
    input  logic [31:0]       issue_Vj,
    input  logic [31:0]       issue_Vk,
    input  logic [ROB_W-1:0]  issue_Qj,
    input  logic [ROB_W-1:0]  issue_Qk,
    input  logic              issue_j_busy,
    input  logic              issue_k_busy,
    input  logic [31:0]       issue_imm,
    input  logic [31:0]       issue_pc,
    input  logic [ROB_W-1:0]  issue_rob,
    output logic              full,
    input  logic              alu_cdb_sgn,
    input  logic [ROB_W-1:0]  alu_cdb_rob,
    input  logic [31:0]       alu_cdb_val,
    input  logic              lsb_cdb_sgn,
    input  logic [ROB_W-1:0]  lsb_cdb_rob,
    input  logic [31:0]       lsb_cdb_val,
    output logic              alu_sgn,
    output logic [5:0]        alu_opcode,
    output logic [31:0]       alu_lhs,
    output logic [31:0]       alu_rhs,
    output logic [31:0]       alu_imm,
    output logic [31:0]       alu_pc,
    output logic [ROB_W-1:0]  alu_rob
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]             busy, j_busy, k_busy;
    logic [RS_SIZE-1:0][31:0]       vj, vk;
    logic [RS_SIZE-1:0][ROB_W-1:0]  qj, qk, rob_q;
    rs_payload_t [RS_SIZE-1:0]      pay;

    logic [RS_SIZE-1:0] ready, grant;
    logic               found;
    logic [IDX_W-1:0]   free_idx, sel_idx;
    logic [31:0]        in_vj, in_vk;
    logic               in_jb, in_kb;

    assign full  = &busy;
    assign ready = busy & ~j_busy & ~k_busy;

    // Lowest free slot / grant index (scan downwards so the lowest wins).
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i])  free_idx = IDX_W'(i);
            if (grant[i])  sel_idx  = IDX_W'(i);
        end
    end

    // Same-cycle bypass: a tag broadcast while the op issues would otherwise
    // be missed forever. ALU CDB has priority over LSB CDB.
    always_comb begin
        in_jb = issue_j_busy;
        in_vj = issue_Vj;
        if (issue_j_busy) begin
            if (alu_cdb_sgn && alu_cdb_rob == issue_Qj) begin
                in_jb = 1'b0;
                in_vj = alu_cdb_val;
            end else if (lsb_cdb_sgn && lsb_cdb_rob == issue_Qj) begin
                in_jb = 1'b0;
                in_vj = lsb_cdb_val;
            end
        end
        in_kb = issue_k_busy;
        in_vk = issue_Vk;
        if (issue_k_busy) begin
            if (alu_cdb_sgn && alu_cdb_rob == issue_Qk) begin
                in_kb = 1'b0;
                in_vk = alu_cdb_val;
            end else if (lsb_cdb_sgn && lsb_cdb_rob == issue_Qk) begin
                in_kb = 1'b0;
                in_vk = lsb_cdb_val;
            end
        end
    end

`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older;

    // Rows of free entries may hold stale bits; a row is cleared on reuse
    // and free entries are never ready, so stale bits never affect a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            older <= '0;
        end else if (rdy && !clear && issue_sgn && !full) begin
            for (int x = 0; x < RS_SIZE; x++) begin
                older[x][free_idx] <= busy[x];
                older[free_idx][x] <= 1'b0;
            end
        end
    end

    alu_rs_select #(.N(RS_SIZE)) u_select (
        .ready (ready),
        .older (older),
        .grant (grant),
        .found (found)
    );
`else
    alu_rs_select #(.N(RS_SIZE)) u_select (
        .ready (ready),
        .grant (grant),
        .found (found)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= '0;
            j_busy     <= '0;
            k_busy     <= '0;
            vj         <= '0;
            vk         <= '0;
            qj         <= '0;
            qk         <= '0;
            rob_q      <= '0;
            pay        <= '0;
            alu_sgn    <= 1'b0;
            alu_opcode <= '0;
            alu_lhs    <= '0;
            alu_rhs    <= '0;
            alu_imm    <= '0;
            alu_pc     <= '0;
            alu_rob    <= '0;
        end else if (!rdy) begin
            alu_sgn <= 1'b0;
        end else if (clear) begin
            busy    <= '0;
            alu_sgn <= 1'b0;
        end else begin
            // Wakeup
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && j_busy[i]) begin
                    if (alu_cdb_sgn && alu_cdb_rob == qj[i]) begin
                        vj[i] <= alu_cdb_val;  j_busy[i] <= 1'b0;
                    end else if (lsb_cdb_sgn && lsb_cdb_rob == qj[i]) begin
                        vj[i] <= lsb_cdb_val;  j_busy[i] <= 1'b0;
                    end
                end
                if (busy[i] && k_busy[i]) begin
                    if (alu_cdb_sgn && alu_cdb_rob == qk[i]) begin
                        vk[i] <= alu_cdb_val;  k_busy[i] <= 1'b0;
                    end else if (lsb_cdb_sgn && lsb_cdb_rob == qk[i]) begin
                        vk[i] <= lsb_cdb_val;  k_busy[i] <= 1'b0;
                    end
                end
            end

            // Dispatch
            alu_sgn <= found;
            if (found) begin
                alu_opcode     <= pay[sel_idx].opcode;
                alu_lhs        <= vj[sel_idx];
                alu_rhs        <= vk[sel_idx];
                alu_imm        <= pay[sel_idx].imm;
                alu_pc         <= pay[sel_idx].pc;
                alu_rob        <= rob_q[sel_idx];
                busy[sel_idx]  <= 1'b0;
            end

            // Issue: free_idx is never the dispatched entry (that one is busy).
            if (issue_sgn && !full) begin
                busy[free_idx]   <= 1'b1;
                j_busy[free_idx] <= in_jb;
                k_busy[free_idx] <= in_kb;
                vj[free_idx]     <= in_vj;
                vk[free_idx]     <= in_vk;
                qj[free_idx]     <= issue_Qj;
                qk[free_idx]     <= issue_Qk;
                rob_q[free_idx]  <= issue_rob;
                pay[free_idx]    <= '{opcode: issue_opcode, imm: issue_imm, pc: issue_pc};
            end
        end
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station for the integer ALU in the Tomasulo core.
- Accepts renamed ALU/branch/jump ops from the issue stage and holds them until both operands are available.
- Wakes pending operands by snooping the ALU and LSB CDB broadcasts.
- Dispatches at most one ready op per cycle on registered outputs that drive the ALU's RS-side inputs directly.

Parameters:
- RS_SIZE, 8, number of entries; power of two, ≥2.
- ROB_W, 4, ROB tag width; matches CDB_ROB_name.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rdy  in  1  global ready; 0 freezes the block.
- clear  in  1  flush on mispredict; synchronous.
- issue_sgn  in  1  new op valid this cycle.
- issue_opcode  in  6  internal opcode (`ADD...`JALR).
- issue_Vj / issue_Vk  in  32  operand values when not pending.
- issue_Qj / issue_Qk  in  ROB_W  producer ROB tag when pending.
- issue_j_busy / issue_k_busy  in  1  operand pending.
- issue_imm, issue_pc  in  32  immediate, instruction PC.
- issue_rob  in  ROB_W  destination ROB entry.
- full  out  1  no free entry.
- alu_cdb_sgn, alu_cdb_rob, alu_cdb_val  in  1/ROB_W/32  ALU broadcast.
- lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_val  in  1/ROB_W/32  LSB broadcast.
- alu_sgn  out  1  dispatch valid (→ ALU RS_sgn).
- alu_opcode  out  6  dispatched opcode.
- alu_lhs, alu_rhs  out  32  operand values.
- alu_imm, alu_pc  out  32  immediate, PC.
- alu_rob  out  ROB_W  destination ROB entry.

Behaviour:
- Reset (rst=0, async):
  - All entries invalid; all alu_* outputs 0; full=0.
- Entry state: busy, opcode, Vj, Vk, Qj, Qk, j_busy, k_busy, imm, pc, rob.
- full:
  - Combinational; 1 iff all RS_SIZE entries are busy.
  - Does not count an entry being dispatched in the same cycle (conservative).
- Issue:
  - issue_sgn with full=0 writes the lowest-index free entry at the clock edge.
  - issue_sgn while full=1 is illegal; the op is ignored and the bench flags it.
- Same-cycle bypass at issue:
  - If issue_j_busy=1 and issue_Qj matches a valid CDB tag in that cycle, store Vj = that CDB value and j_busy = 0.
  - Same rule for k.
- Wakeup:
  - Each edge, every busy entry with j_busy=1 and Qj == alu_cdb_rob (alu_cdb_sgn=1) captures alu_cdb_val and clears j_busy. Same for the LSB CDB and for the k side.
  - If both CDBs carry the same tag, the ALU value wins; this case is illegal by ROB construction.
- Ready condition: busy && !j_busy && !k_busy, evaluated on registered state only.
  - Op issued with both operands ready at edge E is dispatched at edge E+1 (alu_sgn high in cycle E+1..E+2).
  - Operand woken at edge W makes the entry eligible for dispatch at edge W+1.
- Dispatch:
  - At each edge with rdy=1 and clear=0, the selected ready entry is copied to alu_*, alu_sgn is set to 1, and the entry is freed.
  - With no ready entry, alu_sgn is set to 0; the other alu_* outputs hold.
  - alu_sgn is a single-cycle pulse per op.
- Selection: lowest-index ready entry (see Optional Feature).
- Simultaneous events:
  - An entry freed by dispatch cannot be reused by an issue at the same edge.
  - An issue and a dispatch in the same cycle are otherwise independent.
- rdy=0:
  - No issue, wakeup or dispatch.
  - All entry state holds.
  - alu_sgn is cleared to 0 at the edge.
- clear=1 (priority over issue, wakeup and dispatch):
  - At the edge, all entries are invalidated and alu_sgn is set to 0.
  - full=0 in the following cycle.
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro: ALU_RS_OLDEST_FIRST_EN.
- Defined:
  - Maintain an RS_SIZE×RS_SIZE age matrix; older[i][j]=1 means i was issued before j.
  - On issue into entry n: set older[x][n]=1 for every busy x, and older[n][*]=0.
  - Select the ready entry that no other ready entry is older than.
- Undefined:
  - No age matrix; lowest-index ready entry wins.

Decomposition:
- Shared package / defines.v:
  - opcode constants (`ADD...`JALR).
  - `ROBENTRY width.
  - RS_SIZE default.
  - Entry-field struct/typedef.
- One sub-module, alu_rs_select:
  - Inputs: ready vector (and age matrix when the feature is on).
  - Outputs: one-hot grant plus found flag.
  - Purely combinational.

Test Plan:
- Reset then ADDI (Vj=5, imm=3, no deps, rob=2) at edge 1 -> alu_sgn=1 after edge 2 with alu_opcode=`ADDI, alu_lhs=5, alu_imm=3, alu_rob=2; alu_sgn=0 after edge 3.
- ADD with Qj=7 pending; alu_cdb_sgn=1, rob=7, val=0x10 two cycles later -> dispatch one edge after wakeup, alu_lhs=0x10.
- Issue with Qk=4 in the same cycle as lsb_cdb rob=4, val=0xDEAD -> entry stored ready (bypass); dispatched next edge with alu_rhs=0xDEAD.
- Fill all 8 entries with pending ops -> full=1; issue a 9th -> ignored; broadcast a tag -> that entry dispatches and full drops the following cycle.
- 3 entries waiting; assert clear -> full=0; broadcasting the waited tags produces no alu_sgn pulses.
- ALU_RS_OLDEST_FIRST_EN: issue A into entry 3, dispatch one unrelated op to free entry 0, then issue B into entry 0; wake both in the same cycle -> A (rob of A) dispatched first, B next cycle. Undefined build -> B dispatched first.
